// File: rtl/int_to_fp_converter.sv
// rtl/int_to_fp_converter.sv - multi-cycle integer to IEEE-754 converter (FCVT.S.W / FCVT.S.WU)
//
// Purpose: converts a signed or unsigned integer operand to a binary float
//   with selectable rounding mode and fflags generation. Normalisation
//   shifts one bit per cycle, so latency depends on the leading-zero count.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   in_valid   operand valid              in_ready   converter idle and accepting
//   int_val    integer operand            is_signed  1 = two's complement
//   rnd_mode   000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others illegal
//   flush      synchronous abort of any in-flight operation
//   out_valid  result valid               out_ready  consumer accepts result
//   fp_val     {sign, exp, frac}          fflags     {NV, DZ, OF, UF, NX}

module int_to_fp_converter #(
  parameter int INT_WIDTH  = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INT_WIDTH-1:0]              int_val,
  input  logic                              is_signed,
  input  logic [2:0]                        rnd_mode,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]     fp_val,
  output logic [4:0]                        fflags
);

  localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
  // Working register must hold the whole integer and also the mantissa plus
  // guard and at least one sticky bit.
  localparam int WW   = (INT_WIDTH > FRAC_WIDTH + 3) ? INT_WIDTH : FRAC_WIDTH + 3;
  localparam int MW   = FRAC_WIDTH + 1;
  localparam int FPW  = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam logic [EXP_WIDTH-1:0] EXP_INIT = EXP_WIDTH'(BIAS + INT_WIDTH - 1);

  // With INT_WIDTH <= bias the largest exponent (plus a rounding carry) never
  // reaches the all-ones encoding, so no overflow path exists.
  generate
    if (INT_WIDTH > BIAS) begin : g_width_check
      $error("int_to_fp_converter: INT_WIDTH must not exceed the exponent bias");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next;

  logic [INT_WIDTH-1:0]   r_int;
  logic                   r_signed;
  logic [2:0]             r_rnd;
  logic                   r_sign;
  logic [EXP_WIDTH-1:0]   r_exp;
  logic [WW-1:0]          r_work;
  logic [FPW-1:0]         r_fp;
  logic [4:0]             r_flags;

  logic                   w_accept;
  logic                   w_neg;
  logic [INT_WIDTH-1:0]   w_mag;
  logic [WW-1:0]          w_work_load;
  logic                   w_rnd_illegal;
  logic                   w_mag_zero;

  logic [MW-1:0]          w_mant;
  logic                   w_guard;
  logic                   w_sticky;
  logic                   w_nx;
  logic                   w_inc;
  logic [MW:0]            w_sum;
  logic                   w_carry;
  logic [EXP_WIDTH-1:0]   w_exp_rnd;
  logic [FRAC_WIDTH-1:0]  w_frac_rnd;

  // flush in IDLE suppresses acceptance for that cycle.
  assign w_accept      = in_valid & in_ready & ~flush;

  // Most-negative input negates to itself, which read as unsigned is the
  // correct magnitude 2^(INT_WIDTH-1).
  assign w_neg         = r_signed & r_int[INT_WIDTH-1];
  assign w_mag         = w_neg ? (~r_int + 1'b1) : r_int;
  assign w_work_load   = WW'(w_mag) << (WW - INT_WIDTH);
  assign w_rnd_illegal = (r_rnd > 3'd4);
  assign w_mag_zero    = (w_mag == '0);

  // Rounding datapath, evaluated from the normalised working register.
  assign w_mant   = r_work[WW-1 -: MW];
  assign w_guard  = r_work[WW-MW-1];
  assign w_sticky = |r_work[WW-MW-2:0];
  assign w_nx     = w_guard | w_sticky;

  always_comb begin
    w_inc = 1'b0;
    case (r_rnd)
      3'b000:  w_inc = w_guard & (w_sticky | w_mant[0]);
      3'b001:  w_inc = 1'b0;
      3'b010:  w_inc = w_nx & r_sign;
      3'b011:  w_inc = w_nx & ~r_sign;
      3'b100:  w_inc = w_guard;
      default: w_inc = 1'b0;
    endcase
  end

  assign w_sum      = {1'b0, w_mant} + (MW+1)'(w_inc);
  assign w_carry    = w_sum[MW];
  assign w_exp_rnd  = r_exp + EXP_WIDTH'(w_carry);
  assign w_frac_rnd = w_carry ? '0 : w_sum[FRAC_WIDTH-1:0];

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (flush && r_state != S_IDLE) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_next = S_LOAD;
        S_LOAD: begin
          if (w_rnd_illegal || w_mag_zero) w_next = S_DONE;
          else if (w_work_load[WW-1])      w_next = S_ROUND;
          else                             w_next = S_NORM;
        end
        // Leave on the edge whose shift brings a 1 into the MSB.
        S_NORM:  if (r_work[WW-2]) w_next = S_ROUND;
        S_ROUND: w_next = S_DONE;
        S_DONE:  if (out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    in_ready  = (r_state == S_IDLE) & ~RST;
    out_valid = (r_state == S_DONE);
    fp_val    = r_fp;
    fflags    = r_flags;
  end

  // Datapath registers. Result registers are only written on the way into
  // DONE, so they hold across DONE and across a flush.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_int    <= '0;
      r_signed <= 1'b0;
      r_rnd    <= 3'b000;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_work   <= '0;
      r_fp     <= '0;
      r_flags  <= 5'b00000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_int    <= int_val;
            r_signed <= is_signed;
            r_rnd    <= rnd_mode;
          end
        end
        S_LOAD: begin
          if (!flush) begin
            r_sign <= w_neg;
            r_exp  <= EXP_INIT;
            r_work <= w_work_load;
            if (w_rnd_illegal) begin
              r_fp    <= '0;
              r_flags <= 5'b10000;
            end else if (w_mag_zero) begin
              r_fp    <= '0;
              r_flags <= 5'b00000;
            end
          end
        end
        S_NORM: begin
          if (!flush) begin
            r_work <= r_work << 1;
            r_exp  <= r_exp - 1'b1;
          end
        end
        S_ROUND: begin
          if (!flush) begin
            r_fp    <= {r_sign, w_exp_rnd, w_frac_rnd};
            r_flags <= {4'b0000, w_nx};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp_converter.sv
// tb/tb_int_to_fp_converter.sv - directed self-checking bench for int_to_fp_converter

module tb_int_to_fp_converter;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] int_val;
  logic        is_signed;
  logic [2:0]  rnd_mode;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_val;
  logic [4:0]  fflags;

  int errors = 0;
  int checks = 0;

  int_to_fp_converter #(
    .INT_WIDTH (32),
    .EXP_WIDTH (8),
    .FRAC_WIDTH(23)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .int_val  (int_val),
    .is_signed(is_signed),
    .rnd_mode (rnd_mode),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fp_val   (fp_val),
    .fflags   (fflags)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Presents one operand, waits for out_valid (bounded) and returns the
  // observed result and latency in edges counted from the accept edge.
  // Leaves the DUT in DONE; the caller pops it.
  task automatic do_conv(input logic [31:0] v, input logic sg, input logic [2:0] rm,
                         output logic [31:0] fp, output logic [4:0] fl,
                         output int lat, output bit ok);
    @(negedge CLK);
    int_val   = v;
    is_signed = sg;
    rnd_mode  = rm;
    in_valid  = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK);
      lat++;
    end
    fp = fp_val;
    fl = fflags;
  endtask

  task automatic pop();
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || fp_val !== 32'h0 || fflags !== 5'h0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b fp=%h flags=%h, required 0 0 00000000 00",
               in_ready, out_valid, fp_val, fflags);
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_one();
    logic [31:0] fp; logic [4:0] fl; int lat; bit ok;
    do_conv(32'h00000001, 1'b1, 3'b000, fp, fl, lat, ok);
    checks++;
    if (!ok || fp !== 32'h3F800000 || fl !== 5'h00 || lat !== 34) begin
      errors++;
      $display("FAIL one_rne: ok=%0b fp=%h flags=%h lat=%0d, required fp=3f800000 flags=00 lat=34",
               ok, fp, fl, lat);
    end
    pop();
  endtask

  task automatic test_all_ones();
    logic [31:0] fp; logic [4:0] fl; int lat; bit ok;
    do_conv(32'hFFFFFFFF, 1'b1, 3'b000, fp, fl, lat, ok);
    checks++;
    if (!ok || fp !== 32'hBF800000 || fl !== 5'h00) begin
      errors++;
      $display("FAIL neg_one_rne: fp=%h flags=%h, required bf800000 00", fp, fl);
    end
    pop();
    do_conv(32'hFFFFFFFF, 1'b0, 3'b000, fp, fl, lat, ok);
    checks++;
    if (!ok || fp !== 32'h4F800000 || fl !== 5'h01 || lat !== 3) begin
      errors++;
      $display("FAIL umax_rne: fp=%h flags=%h lat=%0d, required 4f800000 01 lat=3", fp, fl, lat);
    end
    pop();
    do_conv(32'hFFFFFFFF, 1'b0, 3'b001, fp, fl, lat, ok);
    checks++;
    if (!ok || fp !== 32'h4F7FFFFF || fl !== 5'h01) begin
      errors++;
      $display("FAIL umax_rtz: fp=%h flags=%h, required 4f7fffff 01", fp, fl);
    end
    pop();
  endtask

  task automatic test_edges();
    logic [31:0] fp; logic [4:0] fl; int lat; bit ok;
    do_conv(32'h80000000, 1'b1, 3'b000, fp, fl, lat, ok);
    checks++;
    if (!ok || fp !== 32'hCF000000 || fl !== 5'h00) begin
      errors++;
      $display("FAIL int_min: fp=%h flags=%h, required cf000000 00", fp, fl);
    end
    pop();
    do_conv(32'h00000000, 1'b1, 3'b000, fp, fl, lat, ok);
    checks++;
    if (!ok || fp !== 32'h00000000 || fl !== 5'h00 || lat !== 2) begin
      errors++;
      $display("FAIL zero: fp=%h flags=%h lat=%0d, required 00000000 00 lat=2", fp, fl, lat);
    end
    pop();
  endtask

  task automatic test_rounding();
    logic [31:0] vin  [5];
    logic [2:0]  rms  [5];
    logic [31:0] want [5];
    logic [31:0] fp; logic [4:0] fl; int lat; bit ok;
    vin[0] = 32'h01000001; rms[0] = 3'b000; want[0] = 32'h4B800000;
    vin[1] = 32'h01000001; rms[1] = 3'b011; want[1] = 32'h4B800001;
    vin[2] = 32'h01000001; rms[2] = 3'b100; want[2] = 32'h4B800001;
    vin[3] = 32'hFEFFFFFF; rms[3] = 3'b010; want[3] = 32'hCB800001;
    vin[4] = 32'hFEFFFFFF; rms[4] = 3'b011; want[4] = 32'hCB800000;
    for (int i = 0; i < 5; i++) begin
      do_conv(vin[i], 1'b1, rms[i], fp, fl, lat, ok);
      checks++;
      if (!ok || fp !== want[i] || fl !== 5'h01 || lat !== 10) begin
        errors++;
        $display("FAIL round_%0d: fp=%h flags=%h lat=%0d, required %h 01 lat=10",
                 i, fp, fl, lat, want[i]);
      end
      pop();
    end
  endtask

  task automatic test_illegal_hold();
    logic [31:0] fp; logic [4:0] fl; int lat; bit ok; int bad; int seen;
    do_conv(32'h00001234, 1'b0, 3'b101, fp, fl, lat, ok);
    checks++;
    if (!ok || fp !== 32'h0 || fl !== 5'h10 || lat !== 2) begin
      errors++;
      $display("FAIL illegal_mode: fp=%h flags=%h lat=%0d, required 00000000 10 lat=2", fp, fl, lat);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      in_valid = (i == 2);
      int_val  = 32'h00000005;
      rnd_mode = 3'b000;
      if (fp_val !== 32'h0 || fflags !== 5'h10 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    @(negedge CLK);
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL done_hold: %0d unstable cycles, required 0", bad);
    end
    pop();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_not_captured: out_valid cycles=%0d in_ready=%b, required 0 1", seen, in_ready);
    end
  endtask

  task automatic test_reset_flush();
    logic [31:0] fp; logic [4:0] fl; int lat; bit ok; int seen;
    do_conv(32'hFFFFFFFF, 1'b1, 3'b000, fp, fl, lat, ok);
    pop();
    // Reset in the middle of a long normalisation.
    @(negedge CLK);
    int_val = 32'h00000001; is_signed = 1'b0; rnd_mode = 3'b000; in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fp_val !== 32'h0 || fflags !== 5'h0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_norm: out_valid=%b fp=%h flags=%h in_ready=%b, required 0 0 0 0",
               out_valid, fp_val, fflags, in_ready);
    end
    @(negedge CLK);
    RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_abandon: out_valid cycles=%0d in_ready=%b, required 0 1", seen, in_ready);
    end
    // Flush in IDLE blocks acceptance.
    @(negedge CLK);
    int_val = 32'h00000007; in_valid = 1'b1; flush = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_block: in_ready=%b, required 1", in_ready);
    end
    do_conv(32'h80000000, 1'b1, 3'b000, fp, fl, lat, ok);
    pop();
    // Flush in the middle of normalisation.
    @(negedge CLK);
    int_val = 32'h00000001; is_signed = 1'b1; in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    flush = 1'b1;
    @(posedge CLK);
    #1 flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || fp_val !== 32'hCF000000 || fflags !== 5'h00) begin
      errors++;
      $display("FAIL flush_mid_norm: in_ready=%b out_valid=%b fp=%h flags=%h, required 1 0 cf000000 00",
               in_ready, out_valid, fp_val, fflags);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_discard: out_valid cycles=%0d, required 0", seen);
    end
    do_conv(32'h00000005, 1'b1, 3'b000, fp, fl, lat, ok);
    checks++;
    if (!ok || fp !== 32'h40A00000 || fl !== 5'h00 || lat !== 32) begin
      errors++;
      $display("FAIL after_flush_five: fp=%h flags=%h lat=%0d, required 40a00000 00 lat=32", fp, fl, lat);
    end
    pop();
  endtask

  initial begin
    RST       = 1'b1;
    in_valid  = 1'b0;
    int_val   = 32'h0;
    is_signed = 1'b0;
    rnd_mode  = 3'b000;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_one();
    test_all_ones();
    test_edges();
    test_rounding();
    test_illegal_hold();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_to_fp_converter.md
Name: int_to_fp_converter

Overview:
- Multi-cycle integer-to-IEEE-754 converter for the FPU: the FCVT.S.W / FCVT.S.WU path.
- Parametrised in integer width and float format.
- Adds signed/unsigned mode, all five RISC-V rounding modes and fflags generation.
- Valid/ready handshake on both sides. Sits between the integer operand mux and the FP register-file writeback.

Parameters:
- INT_WIDTH, 32, width of the integer operand.
- EXP_WIDTH, 8, float exponent width. Bias = 2^(EXP_WIDTH-1)-1.
- FRAC_WIDTH, 23, float stored-fraction width.
- Constraint: INT_WIDTH <= bias, so overflow is impossible. Elaboration error otherwise.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  converter can accept an operand.
- int_val  in  INT_WIDTH  integer operand.
- is_signed  in  1  1 = two's-complement operand, 0 = unsigned.
- rnd_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 illegal.
- flush  in  1  synchronous abort; drops any in-flight result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- fp_val  out  1+EXP_WIDTH+FRAC_WIDTH  result {sign, exp, frac}.
- fflags  out  5  {NV, DZ, OF, UF, NX}. DZ, OF and UF are always 0.

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high (RST).
- While RST is high:
  - state = IDLE; in_ready = 0.
  - out_valid, fp_val, fflags, all internal registers = 0.
  - After release, in_ready = 1.
  - Reset mid-operation abandons the operand; no output is ever produced for it.
- States: IDLE, LOAD, NORM, ROUND, DONE. in_ready = (state == IDLE) and not RST.
- IDLE: on in_valid & in_ready, register int_val, is_signed and rnd_mode; go to LOAD.
- LOAD:
  - sign = is_signed & int_val[MSB].
  - mag = two's-complement absolute value when sign = 1, else int_val. The most-negative value gives mag = 2^(INT_WIDTH-1), as unsigned.
  - exp = bias + INT_WIDTH - 1.
  - Working register is mag left-justified, zero-padded to max(INT_WIDTH, FRAC_WIDTH+3) bits.
  - Next state:
    - Illegal rnd_mode -> DONE with fp_val = 0, NV = 1.
    - mag == 0 -> DONE with fp_val = +0, flags 0.
    - Working MSB set -> ROUND.
    - Otherwise -> NORM.
- NORM: each cycle, shift working register left 1 and decrement exp. Exit to ROUND on the edge where the shifted value's MSB becomes 1.
- ROUND:
  - Take the top FRAC_WIDTH+1 bits (hidden bit + fraction), a guard bit, and sticky = OR of the remaining bits.
  - NX = guard | sticky.
  - Increment the mantissa when:
    - RNE: guard & (sticky | lsb).
    - RTZ: never.
    - RDN: NX & sign.
    - RUP: NX & ~sign.
    - RMM: guard.
  - If the increment carries out of the mantissa: exp += 1, fraction = 0.
  - Go to DONE.
  - If INT_WIDTH <= FRAC_WIDTH+1, NX is always 0.
- DONE:
  - out_valid = 1. fp_val and fflags are held stable until out_ready.
  - On out_valid & out_ready -> IDLE. No back-to-back accept in the same cycle.
- Latency from the accept edge to out_valid visible:
  - Zero operand or illegal mode: 2 edges.
  - Otherwise 3 + k edges, where k = leading zeros of mag in the INT_WIDTH field.
- flush: when sampled high in any state other than IDLE, go to IDLE on that edge. out_valid = 0 and the result is discarded; fp_val and fflags hold their last values. flush in IDLE is a no-op and blocks acceptance that cycle.
- in_valid while busy is ignored; the operand is not captured.

Test Plan:
1. Accept int_val = 0x00000001, signed, RNE -> fp_val 0x3F800000, fflags 0x00, out_valid exactly 34 edges after accept.
2. Signed 0xFFFFFFFF RNE -> 0xBF800000. Unsigned 0xFFFFFFFF RNE -> 0x4F800000, NX (0x01). Unsigned 0xFFFFFFFF RTZ -> 0x4F7FFFFF, NX.
3. Signed 0x80000000 -> 0xCF000000, flags 0. Operand 0x00000000 -> 0x00000000 after 2 edges, flags 0.
4. Signed 0x01000001:
   - RNE -> 0x4B800000, NX.
   - RUP -> 0x4B800001.
   - RMM -> 0x4B800001.
   Signed -16777217:
   - RDN -> 0xCB800001.
   - RUP -> 0xCB800000.
5. rnd_mode = 101 -> fp_val 0x00000000, fflags 0x10. Hold out_ready low 5 cycles in DONE: fp_val and fflags stable, in_ready 0, and an in_valid pulse is not captured.
6. Assert RST mid-NORM -> outputs 0 immediately and in_ready 1 after release. Pulse flush mid-NORM -> IDLE next edge, no out_valid. The following operand 0x00000005 converts to 0x40A00000.
